// File: rtl/md_unit_pkg.sv
// rtl/md_unit_pkg.sv - md_op encodings and default cycle counts for the multiply/divide unit
package md_defs;

  localparam int MD_OP_W = 3;

  localparam logic [MD_OP_W-1:0] MD_NONE  = 3'd0;
  localparam logic [MD_OP_W-1:0] MD_MULT  = 3'd1;
  localparam logic [MD_OP_W-1:0] MD_MULTU = 3'd2;
  localparam logic [MD_OP_W-1:0] MD_DIV   = 3'd3;
  localparam logic [MD_OP_W-1:0] MD_DIVU  = 3'd4;
  localparam logic [MD_OP_W-1:0] MD_MTHI  = 3'd5;
  localparam logic [MD_OP_W-1:0] MD_MTLO  = 3'd6;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int CNT_W_DEF       = 4;

endpackage

// File: rtl/md_unit_if.sv
// rtl/md_unit_if.sv - E-stage to multiply/divide unit signal bundle
interface md_unit_if;
  import md_defs::*;

  logic               start;
  logic [MD_OP_W-1:0] md_op;
  logic [31:0]        rs_val;
  logic [31:0]        rt_val;
  logic               rd_hi;
  logic               busy;
  logic               md_stall;
  logic [31:0]        md_out;
  logic [31:0]        hi;
  logic [31:0]        lo;

  modport master (
    output start, md_op, rs_val, rt_val, rd_hi,
    input  busy, md_stall, md_out, hi, lo
  );

  modport slave (
    input  start, md_op, rs_val, rt_val, rd_hi,
    output busy, md_stall, md_out, hi, lo
  );

endinterface

// File: rtl/md_unit.sv
// rtl/md_unit.sv - multi-cycle MULT/DIV unit owning HI/LO
// Result is computed at accept and staged; HI/LO commit when the busy counter expires.
module md_unit
  import md_defs::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input logic      clk,
  input logic      reset,
  md_unit_if.slave md
);

  logic             busy_q;
  logic [CNT_W-1:0] cnt_q;
  logic [63:0]      res_q;
  logic             res_ok_q;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;

  logic        is_mul;
  logic        is_div;
  logic        start_mul_div;
  logic        div_zero;
  logic [63:0] result;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] uq;
  logic [31:0] ur;

  always_comb begin
    is_mul        = (md.md_op == MD_MULT) || (md.md_op == MD_MULTU);
    is_div        = (md.md_op == MD_DIV)  || (md.md_op == MD_DIVU);
    start_mul_div = md.start && (is_mul || is_div) && !busy_q;
    div_zero      = is_div && (md.rt_val == 32'd0);
  end

  // Signed divide goes through magnitudes so INT_MIN / -1 wraps to INT_MIN without a trap.
  always_comb begin
    abs_a  = md.rs_val[31] ? (32'd0 - md.rs_val) : md.rs_val;
    abs_b  = md.rt_val[31] ? (32'd0 - md.rt_val) : md.rt_val;
    uq     = abs_a / abs_b;
    ur     = abs_a % abs_b;
    result = 64'd0;
    case (md.md_op)
      MD_MULT:  result = {{32{md.rs_val[31]}}, md.rs_val} * {{32{md.rt_val[31]}}, md.rt_val};
      MD_MULTU: result = {32'd0, md.rs_val} * {32'd0, md.rt_val};
      MD_DIV: begin
        result[31:0]  = (md.rs_val[31] ^ md.rt_val[31]) ? (32'd0 - uq) : uq;
        result[63:32] = md.rs_val[31] ? (32'd0 - ur) : ur;
      end
      MD_DIVU:  result = {md.rs_val % md.rt_val, md.rs_val / md.rt_val};
      default:  result = 64'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      res_q    <= 64'd0;
      res_ok_q <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
    end else if (busy_q) begin
      if (cnt_q == CNT_W'(1)) begin
        busy_q   <= 1'b0;
        cnt_q    <= '0;
        res_ok_q <= 1'b0;
        if (res_ok_q) begin
          hi_q <= res_q[63:32];
          lo_q <= res_q[31:0];
        end
      end else begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
    end else if (start_mul_div) begin
      busy_q   <= 1'b1;
      cnt_q    <= is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
      res_q    <= result;
      res_ok_q <= !div_zero;
    end else if (md.start && md.md_op == MD_MTHI) begin
      hi_q <= md.rs_val;
    end else if (md.start && md.md_op == MD_MTLO) begin
      lo_q <= md.rs_val;
    end
  end

  assign md.busy     = busy_q;
  assign md.md_stall = start_mul_div || busy_q;
  assign md.hi       = hi_q;
  assign md.lo       = lo_q;
  assign md.md_out   = md.rd_hi ? hi_q : lo_q;

endmodule

// File: tb/tb_md_unit.sv
// tb/tb_md_unit.sv - scoreboard bench for md_unit
module tb_md_unit;
  import md_defs::*;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  logic clk;
  logic reset;
  int   tests;
  int   fails;
  exp_t sb[$];
  int   busy_cnt;

  md_unit_if bus ();

  md_unit dut (
    .clk   (clk),
    .reset (reset),
    .md    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: count busy cycles and, when busy falls, compare HI/LO with the queued result.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      busy_cnt = 0;
    end else if (bus.busy) begin
      busy_cnt++;
    end else if (busy_cnt > 0) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_underflow: got completion expected none");
      end else begin
        e = sb.pop_front();
        chk({e.name, "_hi"}, bus.hi, e.hi);
        chk({e.name, "_lo"}, bus.lo, e.lo);
        chk({e.name, "_cycles"}, 32'(busy_cnt), 32'(e.cycles));
      end
      busy_cnt = 0;
    end
  end

  // Called just after a negedge: present a mul/div op for one edge.
  task automatic issue(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    bus.start  = 1'b1;
    bus.md_op  = op;
    bus.rs_val = a;
    bus.rt_val = b;
    #1;
    chk({name, "_stall_start"}, 32'(bus.md_stall), 32'd1);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.md_op = MD_NONE;
    chk({name, "_busy_set"}, 32'(bus.busy), 32'd1);
  endtask

  task automatic push(input string name, input logic [31:0] h, input logic [31:0] l,
                      input int n);
    exp_t e;
    e.name = name;
    e.hi = h;
    e.lo = l;
    e.cycles = n;
    sb.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus.busy && n < 50);
    if (bus.busy) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got busy expected idle within 50 cycles", name);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    busy_cnt = 0;
    bus.start  = 1'b0;
    bus.md_op  = MD_NONE;
    bus.rs_val = 32'd0;
    bus.rt_val = 32'd0;
    bus.rd_hi  = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_hi", bus.hi, 32'd0);
    chk("rst_lo", bus.lo, 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_stall", 32'(bus.md_stall), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    push("mult", 32'hFFFFFFFF, 32'hFFFFFFFA, 5);
    issue("mult", MD_MULT, 32'hFFFFFFFE, 32'd3);
    @(negedge clk);
    chk("mult_stall_busy", 32'(bus.md_stall), 32'd1);
    wait_idle("mult");

    bus.rd_hi = 1'b1;
    push("multu", 32'hFFFFFFFE, 32'h00000001, 5);
    issue("multu", MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    @(negedge clk);
    chk("multu_old_hi", bus.md_out, 32'hFFFFFFFF);
    wait_idle("multu");
    chk("multu_new_hi", bus.md_out, 32'hFFFFFFFE);
    bus.rd_hi = 1'b0;
    #1;
    chk("multu_mdout_lo", bus.md_out, 32'h00000001);
    @(negedge clk);

    push("div", 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    issue("div", MD_DIV, 32'hFFFFFFF9, 32'd2);
    wait_idle("div");

    push("divu0", 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    issue("divu0", MD_DIVU, 32'd7, 32'd0);
    wait_idle("divu0");

    push("div_ovf", 32'h00000000, 32'h80000000, 10);
    issue("div_ovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF);
    wait_idle("div_ovf");

    bus.start  = 1'b1;
    bus.md_op  = MD_MTHI;
    bus.rs_val = 32'h12345678;
    #1;
    chk("mthi_stall", 32'(bus.md_stall), 32'd0);
    @(posedge clk);
    #1;
    chk("mthi_hi", bus.hi, 32'h12345678);
    chk("mthi_lo_keep", bus.lo, 32'h80000000);
    chk("mthi_busy", 32'(bus.busy), 32'd0);
    bus.md_op  = MD_MTLO;
    bus.rs_val = 32'h9ABCDEF0;
    @(posedge clk);
    #1;
    chk("mtlo_lo", bus.lo, 32'h9ABCDEF0);
    chk("mtlo_hi_keep", bus.hi, 32'h12345678);
    chk("mtlo_busy", 32'(bus.busy), 32'd0);
    bus.md_op  = MD_NONE;
    bus.rs_val = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    chk("none_hi", bus.hi, 32'h12345678);
    chk("none_lo", bus.lo, 32'h9ABCDEF0);
    chk("none_busy", 32'(bus.busy), 32'd0);
    bus.start = 1'b0;
    @(negedge clk);

    // Start held through busy with new operands, then an MTLO mid-busy: all ignored.
    push("mult_hold", 32'h00000000, 32'd30, 5);
    bus.start  = 1'b1;
    bus.md_op  = MD_MULT;
    bus.rs_val = 32'd5;
    bus.rt_val = 32'd6;
    @(posedge clk);
    #1;
    bus.rs_val = 32'd100;
    bus.rt_val = 32'd100;
    repeat (2) @(posedge clk);
    #1;
    bus.md_op  = MD_MTLO;
    bus.rs_val = 32'h1;
    @(posedge clk);
    #1;
    chk("mtlo_ignored", bus.lo, 32'h9ABCDEF0);
    bus.start = 1'b0;
    bus.md_op = MD_NONE;
    wait_idle("mult_hold");

    push("b2b_div", 32'd2, 32'd14, 10);
    issue("b2b_div", MD_DIV, 32'd100, 32'd7);
    wait_idle("b2b_div");
    chk("b2b_gap_low", 32'(bus.busy), 32'd0);
    push("b2b_mult", 32'd0, 32'd56, 5);
    issue("b2b_mult", MD_MULT, 32'd7, 32'd8);
    wait_idle("b2b_mult");

    issue("abort_div", MD_DIV, 32'd50, 32'd5);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_hi", bus.hi, 32'd0);
    chk("abort_lo", bus.lo, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    push("post_rst", 32'd0, 32'd12, 5);
    issue("post_rst", MD_MULT, 32'd3, 32'd4);
    wait_idle("post_rst");
    @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
